// File: rtl/det3_dfs_core_pkg.sv
// det3_dfs_core shared types, frame schedule and Sarrus term table.
// Everything the core computes is modulo 2^W.
package det3_dfs_core_pkg;

  localparam int W         = 16;
  localparam int FRAME_LEN = 32;
  localparam int CW        = $clog2(FRAME_LEN);

  localparam int CAP_END   = 8;
  localparam int D1_START  = 9;
  localparam int D1_LATCH  = 16;
  localparam int D2_START  = 15;
  localparam int D2_LATCH  = 22;
  localparam int DM_OP     = 23;
  localparam int DM_LATCH  = 25;
  localparam int OUT_START = 26;
  localparam int TERM_END  = D2_START + 5;

  typedef logic [CW-1:0]       cnt_t;
  typedef logic [3:0]          idx_t;
  typedef logic signed [W-1:0] data_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_CAP,
    PH_TERM,
    PH_DM
  } phase_t;

  typedef struct packed {
    idx_t a;
    idx_t b;
    idx_t c;
    logic neg;
  } term_t;

  // 0..5 build det_1, 6..11 build det_2 from the row-reversed matrix
  function automatic term_t term_lut(idx_t t);
    term_t r;
    r = '0;
    unique case (t)
      4'd0:    r = '{4'd0, 4'd4, 4'd8, 1'b0};
      4'd1:    r = '{4'd1, 4'd5, 4'd6, 1'b0};
      4'd2:    r = '{4'd2, 4'd3, 4'd7, 1'b0};
      4'd3:    r = '{4'd2, 4'd4, 4'd6, 1'b1};
      4'd4:    r = '{4'd0, 4'd5, 4'd7, 1'b1};
      4'd5:    r = '{4'd1, 4'd3, 4'd8, 1'b1};
      4'd6:    r = '{4'd6, 4'd4, 4'd2, 1'b0};
      4'd7:    r = '{4'd7, 4'd5, 4'd0, 1'b0};
      4'd8:    r = '{4'd8, 4'd3, 4'd1, 1'b0};
      4'd9:    r = '{4'd8, 4'd4, 4'd0, 1'b1};
      4'd10:   r = '{4'd6, 4'd5, 4'd1, 1'b1};
      4'd11:   r = '{4'd7, 4'd3, 4'd2, 1'b1};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic phase_t phase_of(cnt_t c);
    phase_t p;
    p = PH_IDLE;
    if (c <= cnt_t'(CAP_END))
      p = PH_CAP;
    else if (c >= cnt_t'(D1_START) &&
             c <= cnt_t'(TERM_END))
      p = PH_TERM;
    else if (c == cnt_t'(DM_OP))
      p = PH_DM;
    return p;
  endfunction

  function automatic idx_t idx_of(cnt_t c);
    idx_t i;
    i = '0;
    if (c <= cnt_t'(CAP_END))
      i = idx_t'(c);
    else if (c >= cnt_t'(D1_START) &&
             c <= cnt_t'(TERM_END))
      i = idx_t'(c - cnt_t'(D1_START));
    return i;
  endfunction

endpackage

// File: rtl/det3_dfs_core_if.sv
// Stream and MACC3 bus of det3_dfs_core.
// master is the core side, slave the stream source and MACC unit.
interface det3_dfs_core_if;
  import det3_dfs_core_pkg::*;

  logic  sync_in;
  logic  sync_out;
  data_t in;
  data_t out;
  data_t MACC3_0_A;
  data_t MACC3_0_B;
  data_t MACC3_0_C;
  logic  MACC3_0_clear;
  logic  MACC3_0_sub;
  data_t MACC3_0_Y;

  modport master (
    input  in,
    input  MACC3_0_Y,
    output sync_in,
    output sync_out,
    output out,
    output MACC3_0_A,
    output MACC3_0_B,
    output MACC3_0_C,
    output MACC3_0_clear,
    output MACC3_0_sub
  );

  modport slave (
    output in,
    output MACC3_0_Y,
    input  sync_in,
    input  sync_out,
    input  out,
    input  MACC3_0_A,
    input  MACC3_0_B,
    input  MACC3_0_C,
    input  MACC3_0_clear,
    input  MACC3_0_sub
  );

endinterface

// File: rtl/det3_dfs_core_sched.sv
// Frame counter for det3_dfs_core.
// Phase, operand index and clear are registered from the next count.
module det3_sched
  import det3_dfs_core_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  output cnt_t   cnt,
  output phase_t phase,
  output idx_t   idx,
  output logic   clear,
  output logic   sync
);

  cnt_t cnt_nxt;

  assign cnt_nxt = (cnt == cnt_t'(FRAME_LEN - 1)) ?
                   '0 : cnt + 1'b1;

  // Counter idles at 0 in reset, so sync must be masked
  assign sync = (cnt == '0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_CAP;
      idx   <= '0;
      clear <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_of(cnt_nxt);
      idx   <= idx_of(cnt_nxt);
      clear <= (cnt_nxt == cnt_t'(D1_START)) ||
               (cnt_nxt == cnt_t'(D2_START)) ||
               (cnt_nxt == cnt_t'(DM_OP));
    end
  end

endmodule

// File: rtl/det3_dfs_core.sv
// Statically scheduled 3x3 determinant core driving one MACC3 unit.
// Emits det_1, det_2 and det_1*det_2 once per frame.
module det3_dfs_core
  import det3_dfs_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  det3_dfs_core_if.master   bus
);

  cnt_t   cnt;
  phase_t phase;
  idx_t   idx;
  logic   clr;
  logic   sync;
  term_t  t;

  data_t  m [9];
  data_t  det_1;
  data_t  det_2;
  data_t  det_m;

  det3_sched u_sched (
    .clk   (clk),
    .rst   (rst),
    .cnt   (cnt),
    .phase (phase),
    .idx   (idx),
    .clear (clr),
    .sync  (sync)
  );

  assign bus.sync_in = sync;
  assign t = term_lut(idx);

  always_comb begin
    bus.MACC3_0_A     = '0;
    bus.MACC3_0_B     = '0;
    bus.MACC3_0_C     = '0;
    bus.MACC3_0_clear = 1'b0;
    bus.MACC3_0_sub   = 1'b0;
    unique case (1'b1)
      (phase == PH_TERM): begin
        bus.MACC3_0_A     = m[t.a];
        bus.MACC3_0_B     = m[t.b];
        bus.MACC3_0_C     = m[t.c];
        bus.MACC3_0_clear = clr;
        bus.MACC3_0_sub   = t.neg;
      end
      (phase == PH_DM): begin
        bus.MACC3_0_A     = det_1;
        bus.MACC3_0_B     = det_2;
        bus.MACC3_0_C     = data_t'(1);
        bus.MACC3_0_clear = clr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++)
        m[i] <= '0;
    end else if (phase == PH_CAP) begin
      m[idx] <= bus.in;
    end
  end

  // Y carries an op's result two cycles after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_1 <= '0;
      det_2 <= '0;
      det_m <= '0;
    end else begin
      if (cnt == cnt_t'(D1_LATCH))
        det_1 <= bus.MACC3_0_Y;
      if (cnt == cnt_t'(D2_LATCH))
        det_2 <= bus.MACC3_0_Y;
      if (cnt == cnt_t'(DM_LATCH))
        det_m <= bus.MACC3_0_Y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out      <= '0;
      bus.sync_out <= 1'b0;
    end else begin
      bus.sync_out <= 1'b0;
      unique case (1'b1)
        (cnt == cnt_t'(OUT_START - 1)): begin
          bus.out      <= det_1;
          bus.sync_out <= 1'b1;
        end
        (cnt == cnt_t'(OUT_START)):
          bus.out <= det_2;
        (cnt == cnt_t'(OUT_START + 1)):
          bus.out <= det_m;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det3_dfs_core.sv
// Bench for det3_dfs_core with a behavioural MACC3 unit.
// Expected determinants come from a cofactor expansion queued per frame.
module tb_det3_dfs_core;
  import det3_dfs_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  det3_dfs_core_if bus ();

  det3_dfs_core u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  data_t acc;
  data_t prod;
  data_t base;

  assign prod = data_t'(bus.MACC3_0_A *
                        bus.MACC3_0_B *
                        bus.MACC3_0_C);
  assign base = bus.MACC3_0_clear ? '0 : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      bus.MACC3_0_Y <= '0;
    end else begin
      bus.MACC3_0_Y <= acc;
      acc <= bus.MACC3_0_sub ? base - prod
                             : base + prod;
    end
  end

  int    n_run  = 0;
  int    n_fail = 0;
  data_t exp_q [$];
  data_t mat [9];

  task automatic check(string tag, int got, int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic set_mat(int a0, int a1, int a2,
                         int a3, int a4, int a5,
                         int a6, int a7, int a8);
    mat[0] = data_t'(a0); mat[1] = data_t'(a1);
    mat[2] = data_t'(a2); mat[3] = data_t'(a3);
    mat[4] = data_t'(a4); mat[5] = data_t'(a5);
    mat[6] = data_t'(a6); mat[7] = data_t'(a7);
    mat[8] = data_t'(a8);
  endtask

  function automatic void push_expected();
    longint d;
    data_t  d1;
    data_t  d2;
    d = longint'(mat[0]) *
          (longint'(mat[4]) * mat[8] -
           longint'(mat[5]) * mat[7])
      - longint'(mat[1]) *
          (longint'(mat[3]) * mat[8] -
           longint'(mat[5]) * mat[6])
      + longint'(mat[2]) *
          (longint'(mat[3]) * mat[7] -
           longint'(mat[4]) * mat[6]);
    d1 = data_t'(d);
    d2 = -d1;
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(data_t'(longint'(d1) *
                            longint'(d2)));
  endfunction

  // Leaves the bench at the negedge of frame cycle 9
  task automatic drive_frame(string tag, bit push);
    int n = 0;
    while (!bus.sync_in && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sync_in"}, int'(bus.sync_in), 1);
    for (int i = 0; i < 9; i++) begin
      bus.in = mat[i];
      @(negedge clk);
    end
    if (push)
      push_expected();
  endtask

  task automatic collect(string tag);
    int    k = 9;
    data_t e;
    while (!bus.sync_out && k < 64) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, OUT_START);
    for (int j = 0; j < 3; j++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front()
                              : '0;
      check($sformatf("%s_out%0d", tag, j),
            int'(bus.out), int'(e));
      check($sformatf("%s_sync_out%0d", tag, j),
            int'(bus.sync_out), (j == 0) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int n_sync;
    int n_so;
    bus.in = '0;

    repeat (3) @(negedge clk);
    check("rst_out", int'(bus.out), 0);
    check("rst_sync_out", int'(bus.sync_out), 0);
    check("rst_sync_in", int'(bus.sync_in), 0);
    check("rst_macc_a", int'(bus.MACC3_0_A), 0);
    check("rst_macc_clear",
          int'(bus.MACC3_0_clear), 0);

    rst = 1'b0;
    #1;
    n_sync = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if (bus.sync_in)
        n_sync++;
      @(negedge clk);
    end
    check("sync_in_rate", n_sync, 2);

    set_mat(4, 7, 5, 2, 6, 4, 9, 2, 1);
    drive_frame("ex", 1'b1);
    collect("ex");

    set_mat(1, 1, 1, 1, 1, 1, 1, 1, 1);
    drive_frame("ones", 1'b1);
    collect("ones");

    set_mat(1, 0, 0, 0, 1, 0, 0, 0, 1);
    drive_frame("ident", 1'b1);
    collect("ident");

    set_mat(100, 0, 0, 0, 100, 0, 0, 0, 100);
    drive_frame("wrap", 1'b1);
    collect("wrap");

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 9; i++)
        mat[i] = data_t'($urandom);
      drive_frame($sformatf("rnd%0d", r), 1'b1);
      collect($sformatf("rnd%0d", r));
    end

    set_mat(3, -2, 8, 1, 0, -5, 7, 4, 6);
    drive_frame("abort", 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_so = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.sync_out)
        n_so++;
      @(negedge clk);
    end
    check("abort_sync_out", n_so, 0);
    check("abort_out", int'(bus.out), 0);
    check("abort_sync_in", int'(bus.sync_in), 0);
    rst = 1'b0;
    #1;

    set_mat(2, -3, 1, 5, 4, -1, -2, 6, 3);
    drive_frame("post", 1'b1);
    collect("post");

    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/det3_dfs_core.md
Name: det3_dfs_core

Overview:
- Statically scheduled dataflow core that computes 3x3 matrix determinants from a serial input stream.
- Each frame it accepts 9 signed 16-bit elements (row-major m0..m8) and returns three words: det_1, det_2 and det_M = det_1*det_2.
- All multiply-accumulate work is issued to one external MACC3 unit, which performs triple product and accumulate with 2-cycle result latency.
- The core owns only the frame schedule, element storage and result registers.

Parameters:
- FRAME_LEN, 32, cycles per frame; frame counter wraps FRAME_LEN-1 -> 0; must be >= 29.
- W, 16, data width; all data is signed two's complement.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- sync_in  output  1  high in frame cycle 0; `in` is sampled that edge and on the 8 following edges.
- sync_out  output  1  high in the cycle det_1 is on `out`.
- in  input  W  serial matrix element stream.
- out  output  W  result stream: det_1, det_2, det_M on consecutive cycles.
- MACC3_0_A  output  W  MACC operand A.
- MACC3_0_B  output  W  MACC operand B.
- MACC3_0_C  output  W  MACC operand C.
- MACC3_0_clear  output  1  discard accumulator before this op.
- MACC3_0_sub  output  1  subtract the product instead of adding it.
- MACC3_0_Y  input  W  MACC result.

Behaviour:
- MACC contract:
  - On each edge, acc <= (clear ? 0 : acc) ± A*B*C, truncated to W.
  - Y <= acc one edge later.
  - Result of an op issued in cycle k is readable on Y in cycle k+2.
- Reset (asynchronous):
  - Frame counter = 0.
  - out = 0, sync_out = 0, sync_in = 0.
  - MACC outputs = 0 and clear = 0 while rst is high.
- After release, counter increments every cycle and sync_in = (counter == 0).
- Schedule by frame cycle c:
  - c=0..8: register in as m[c]. MACC idle: A=B=C=0, clear=0, sub=0.
  - c=9..14, det_1 terms (Sarrus) in order: +m0m4m8, +m1m5m6, +m2m3m7, -m2m4m6, -m0m5m7, -m1m3m8. clear=1 on c=9 only.
  - c=16: latch MACC3_0_Y into det_1.
  - c=15..20, det_2 (rows reversed) terms: +m6m4m2, +m7m5m0, +m8m3m1, -m8m4m0, -m6m5m1, -m7m3m2. clear=1 on c=15. Note det_2 = -det_1 arithmetically.
  - c=22: latch MACC3_0_Y into det_2.
  - c=23: A=det_1, B=det_2, C=1, clear=1, sub=0.
  - c=25: latch MACC3_0_Y into det_M.
  - c=21, 24, 26..FRAME_LEN-1: MACC idle.
- Output timing: out is registered, so values appear the cycle after the assignment edge.
  - c=26: out=det_1, sync_out=1.
  - c=27: out=det_2.
  - c=28: out=det_M.
  - Otherwise sync_out=0 and out holds its last value.
- Arithmetic: everything is modulo 2^W; overflow wraps silently with no saturation.
- Frames run back-to-back forever. Element and result registers are overwritten each frame. There is no stall or back-pressure.
- Asserting rst mid-frame aborts the frame; the next frame restarts at cycle 0 after release.

Decomposition:
- Shared package: W, FRAME_LEN, and the schedule-cycle constants (CAP_END=8, D1_START=9, D1_LATCH=16, D2_START=15, D2_LATCH=22, DM_OP=23, DM_LATCH=25, OUT_START=26).
- Optionally a package table of the 12 term index triples with sign bits.
- One sub-module is natural: det3_sched, the frame counter that decodes the phase/op index.
- Datapath muxes remain in the top level.

Test Plan:
- Reset then release -> out=0, sync_out=0 during reset; sync_in rises exactly once per 32 cycles after release.
- Stream 4,7,5,2,6,4,9,2,1 starting at the sync_in edge -> 18 cycles after the last element sync_out=1 with out=-20, then 20, then -400.
- Hold in=1 for the next frame -> outputs 0, 0, 0.
- Identity matrix 1,0,0,0,1,0,0,0,1 -> outputs 1, -1, -1.
- Elements 100,0,0,0,100,0,0,0,100 -> det_1 = 10^6 mod 2^16 = 16960; det_2 = -16960; det_M = wrapped product.
- Assert rst at frame cycle 12 then release -> no sync_out from the aborted frame; the next frame computes correctly.
